serial_to_parallel_lane: RTL and testbench

SERIAL_TO_PARALLEL_LANE -- requirements
Module: serial_to_parallel_lane

---
 rtl/serial_to_parallel_lane_pkg.sv | 22 ++
 rtl/serial_to_parallel_lane_if.sv | 13 +
 rtl/serial_to_parallel_lane_comma_detect.sv | 27 ++
 rtl/serial_to_parallel_lane.sv | 144 ++++++++++++++
 tb/tb_serial_to_parallel_lane.sv | 135 +++++++++++++
 5 files changed

// File: rtl/serial_to_parallel_lane_pkg.sv
// Shared lane definitions: FSM state encoding, COMMA default and word geometry,
// common to the striping, parallel-to-serial and serial-to-parallel stages.
package serial_to_parallel_lane_pkg;

  localparam int unsigned BYTE_W    = 8;
  localparam int unsigned WORD_W    = 32;
  localparam int unsigned BIT_CNT_W = 5;

  localparam logic [BYTE_W-1:0] COMMA_DEFAULT = 8'hBC;

  typedef enum logic [1:0] {
    ST_SEARCH  = 2'd0,
    ST_LOCKING = 2'd1,
    ST_ACTIVE  = 2'd2
  } lane_state_e;

  // Idle word: the alignment byte repeated across the whole word.
  function automatic logic [WORD_W-1:0] idle_word(input logic [BYTE_W-1:0] comma);
    return {4{comma}};
  endfunction

endpackage

// File: rtl/serial_to_parallel_lane_if.sv
// Lane bus: serial bit in, assembled word and status out.
interface serial_to_parallel_lane_if;
  import serial_to_parallel_lane_pkg::*;

  logic              data_in;
  logic [WORD_W-1:0] data_out;
  logic              valid_out;
  logic              active;

  modport master (output data_in, input data_out, input valid_out, input active);
  modport slave  (input data_in, output data_out, output valid_out, output active);

endinterface

// File: rtl/serial_to_parallel_lane_comma_detect.sv
// 8-bit serial shift register with a COMMA compare on the byte it loads this cycle.
module serial_to_parallel_lane_comma_detect
  import serial_to_parallel_lane_pkg::*;
#(
  parameter logic [BYTE_W-1:0] COMMA = COMMA_DEFAULT
) (
  input  logic              clk_32f,
  input  logic              reset,
  input  logic              data_in,
  output logic [BYTE_W-1:0] shift_q,
  output logic              match_c
);

  logic [BYTE_W-1:0] shift_c;

  assign shift_c = {shift_q[BYTE_W-2:0], data_in};
  assign match_c = (shift_c == COMMA);

  always_ff @(posedge clk_32f) begin
    if (!reset) begin
      shift_q <= '0;
    end else begin
      shift_q <= shift_c;
    end
  end

endmodule

// File: rtl/serial_to_parallel_lane.sv
// Serial-to-parallel lane: comma alignment, lock FSM and 32-bit word assembly.
// Optional lock loss on long non-idle runs when S2P_LOCK_LOSS_EN is defined.
module serial_to_parallel_lane
  import serial_to_parallel_lane_pkg::*;
#(
  parameter logic [BYTE_W-1:0] COMMA      = COMMA_DEFAULT,
  parameter int unsigned       LOCK_BYTES = 4,
  parameter int unsigned       MAX_GAP    = 16
) (
  input  logic                   clk_32f,
  input  logic                   reset,
  serial_to_parallel_lane_if.slave lane
);

  localparam int unsigned         CNT_W       = $clog2(LOCK_BYTES + 1);
  localparam int unsigned         UPPER_W     = WORD_W - BYTE_W - 1;
  localparam logic [CNT_W-1:0]    LOCK_TARGET = CNT_W'(LOCK_BYTES);
  localparam logic [WORD_W-1:0]   IDLE_WORD   = idle_word(COMMA);
  localparam logic [BIT_CNT_W-1:0] LAST_BIT   = BIT_CNT_W'(WORD_W - 1);

  if (LOCK_BYTES == 0 || MAX_GAP == 0) begin : g_param_check
    $error("serial_to_parallel_lane: LOCK_BYTES and MAX_GAP must be non-zero");
  end

  lane_state_e          state_q;
  logic [CNT_W-1:0]     comma_cnt_q;
  logic [BIT_CNT_W-1:0] bit_cnt_q;
  logic [UPPER_W-1:0]   upper_q;
  logic [BYTE_W-1:0]    shift_q;
  logic                 match_c;
  logic [WORD_W-1:0]    word_c;
  logic                 byte_edge_c;
  logic                 word_edge_c;
  logic                 idle_c;
  logic                 lose_c;

  serial_to_parallel_lane_comma_detect #(
    .COMMA (COMMA)
  ) u_comma_detect (
    .clk_32f (clk_32f),
    .reset   (reset),
    .data_in (lane.data_in),
    .shift_q (shift_q),
    .match_c (match_c)
  );

  // Word bits 31..9 trail the byte shifter by 8 cycles; bits 8..0 are shifter plus current bit.
  assign word_c      = {upper_q, shift_q, lane.data_in};
  assign byte_edge_c = (bit_cnt_q[2:0] == 3'd7);
  assign word_edge_c = (bit_cnt_q == LAST_BIT);
  assign idle_c      = (word_c == IDLE_WORD);

`ifdef S2P_LOCK_LOSS_EN
  localparam int unsigned GAP_W = $clog2(MAX_GAP + 1);

  logic [GAP_W-1:0] gap_q;

  assign lose_c = (state_q == ST_ACTIVE) && word_edge_c && !idle_c
                  && (gap_q >= GAP_W'(MAX_GAP));

  // Run length of consecutive non-idle words while active.
  always_ff @(posedge clk_32f) begin
    if (!reset) begin
      gap_q <= '0;
    end else if (state_q != ST_ACTIVE || lose_c) begin
      gap_q <= '0;
    end else if (word_edge_c) begin
      gap_q <= idle_c ? '0 : gap_q + GAP_W'(1);
    end
  end
`else
  assign lose_c = 1'b0;
`endif

  always_ff @(posedge clk_32f) begin
    if (!reset) begin
      state_q        <= ST_SEARCH;
      comma_cnt_q    <= '0;
      bit_cnt_q      <= '0;
      upper_q        <= '0;
      lane.data_out  <= '0;
      lane.valid_out <= 1'b0;
      lane.active    <= 1'b0;
    end else begin
      upper_q <= {upper_q[UPPER_W-2:0], shift_q[BYTE_W-1]};
      unique case (state_q)
        ST_SEARCH: begin
          lane.data_out  <= '0;
          lane.valid_out <= 1'b0;
          lane.active    <= 1'b0;
          bit_cnt_q      <= '0;
          if (match_c) begin
            if (LOCK_BYTES == 1) begin
              state_q     <= ST_ACTIVE;
              lane.active <= 1'b1;
              comma_cnt_q <= LOCK_TARGET;
            end else begin
              state_q     <= ST_LOCKING;
              comma_cnt_q <= CNT_W'(1);
            end
          end
        end
        ST_LOCKING: begin
          lane.data_out  <= '0;
          lane.valid_out <= 1'b0;
          lane.active    <= 1'b0;
          bit_cnt_q      <= bit_cnt_q + BIT_CNT_W'(1);
          // Only bytes landing on the boundary fixed by the first match count.
          if (byte_edge_c) begin
            if (!match_c) begin
              state_q     <= ST_SEARCH;
              comma_cnt_q <= '0;
              bit_cnt_q   <= '0;
            end else if (comma_cnt_q + CNT_W'(1) == LOCK_TARGET) begin
              state_q     <= ST_ACTIVE;
              lane.active <= 1'b1;
              comma_cnt_q <= LOCK_TARGET;
              bit_cnt_q   <= '0;
            end else begin
              comma_cnt_q <= comma_cnt_q + CNT_W'(1);
            end
          end
        end
        ST_ACTIVE: begin
          bit_cnt_q <= bit_cnt_q + BIT_CNT_W'(1);
          if (word_edge_c) begin
            lane.data_out  <= idle_c ? '0 : word_c;
            lane.valid_out <= !idle_c;
          end
          if (lose_c) begin
            state_q     <= ST_SEARCH;
            lane.active <= 1'b0;
            comma_cnt_q <= '0;
            bit_cnt_q   <= '0;
          end
        end
        default: begin
          state_q <= ST_SEARCH;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_to_parallel_lane.sv
// Directed bench for serial_to_parallel_lane; lock-loss expectations follow S2P_LOCK_LOSS_EN.
module tb_serial_to_parallel_lane;

`ifdef S2P_LOCK_LOSS_EN
  localparam bit LOSS_EN = 1'b1;
`else
  localparam bit LOSS_EN = 1'b0;
`endif

  logic clk_32f = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;

  serial_to_parallel_lane_if lane();

  serial_to_parallel_lane #(
    .COMMA      (8'hBC),
    .LOCK_BYTES (4),
    .MAX_GAP    (2)
  ) dut (
    .clk_32f (clk_32f),
    .reset   (reset),
    .lane    (lane.slave)
  );

  always #5 clk_32f = ~clk_32f;

  task automatic tick(input logic b);
    lane.data_in = b;
    @(posedge clk_32f);
    #1;
  endtask

  task automatic send_bits(input logic [31:0] v, input int n);
    for (int i = n - 1; i >= 0; i--) tick(v[i]);
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %08h expected %08h", tag, obs, exp);
    end
  endtask

  task automatic check_out(input string tag, input logic [31:0] d, input logic v, input logic a);
    check({tag, "/data"}, lane.data_out, d);
    check({tag, "/valid"}, 32'(lane.valid_out), 32'(v));
    check({tag, "/active"}, 32'(lane.active), 32'(a));
  endtask

  // Sends one word; checks the previous output still holds after 31 bits, then the new one.
  task automatic word(input string tag, input logic [31:0] w,
                      input logic [31:0] prev_d, input logic prev_v,
                      input logic [31:0] exp_d, input logic exp_v, input logic exp_a);
    send_bits(w >> 1, 31);
    check_out({tag, "_hold"}, prev_d, prev_v, 1'b1);
    tick(w[0]);
    check_out(tag, exp_d, exp_v, exp_a);
  endtask

  initial begin
    logic [31:0] v3;
    int          pulses;
    v3           = 32'h0000_0003;
    pulses       = 0;
    reset        = 1'b0;
    lane.data_in = 1'b0;

    repeat (3) @(posedge clk_32f);
    #1;
    check_out("reset", 32'h0, 1'b0, 1'b0);
    reset = 1'b1;

    // Four aligned commas: active only once the 32nd bit is taken.
    send_bits(32'hBCBC_BCBC >> 1, 31);
    check_out("lock_pre", 32'h0, 1'b0, 1'b0);
    tick(1'b0);
    check_out("lock", 32'h0, 1'b0, 1'b1);

    word("ff",    32'hFFFF_FFFF, 32'h0,         1'b0, 32'hFFFF_FFFF, 1'b1, 1'b1);
    word("dd",    32'hDDDD_DDDD, 32'hFFFF_FFFF, 1'b1, 32'hDDDD_DDDD, 1'b1, 1'b1);
    word("idle0", 32'hBCBC_BCBC, 32'hDDDD_DDDD, 1'b1, 32'h0,         1'b0, 1'b1);
    word("ee",    32'hEEEE_EEEE, 32'h0,         1'b0, 32'hEEEE_EEEE, 1'b1, 1'b1);
    word("idle1", 32'hBCBC_BCBC, 32'hEEEE_EEEE, 1'b1, 32'h0,         1'b0, 1'b1);
    word("cc",    32'hCCCC_CCCC, 32'h0,         1'b0, 32'hCCCC_CCCC, 1'b1, 1'b1);

    // Reset pulse after 17 bits of a word discards it.
    send_bits(v3 >> 15, 17);
    reset = 1'b0;
    tick(1'b0);
    check_out("rst_mid", 32'h0, 1'b0, 1'b0);
    reset = 1'b1;
    for (int i = 14; i >= 0; i--) begin
      tick(v3[i]);
      if (lane.valid_out !== 1'b0 || lane.active !== 1'b0) pulses++;
    end
    for (int i = 0; i < 17; i++) begin
      tick(1'b0);
      if (lane.valid_out !== 1'b0 || lane.active !== 1'b0) pulses++;
    end
    check("rst_no_pulse", 32'(pulses), 32'h0);

    // Two commas then a non-comma byte fall back to search.
    tick(1'b1); tick(1'b0); tick(1'b1);
    send_bits(32'hBC, 8);
    send_bits(32'hBC, 8);
    check_out("locking", 32'h0, 1'b0, 1'b0);
    send_bits(32'h00, 8);
    check_out("search_ret", 32'h0, 1'b0, 1'b0);

    // Comma straddling the fixed boundary must not count toward lock.
    send_bits(32'hBC, 8);
    send_bits(32'h0, 3);
    send_bits(32'hBC, 8);
    send_bits(32'hBC, 8);
    send_bits(32'hBC, 8);
    check_out("straddle", 32'h0, 1'b0, 1'b0);
    send_bits(32'hBC, 8);
    check_out("relock", 32'h0, 1'b0, 1'b1);

    // Three consecutive non-idle words; lock loss on the third when enabled.
    word("idle2", 32'hBCBC_BCBC, 32'h0, 1'b0, 32'h0, 1'b0, 1'b1);
    word("w1", 32'h0000_0001, 32'h0,         1'b0, 32'h0000_0001, 1'b1, 1'b1);
    word("w2", 32'h0000_0002, 32'h0000_0001, 1'b1, 32'h0000_0002, 1'b1, 1'b1);
    word("w3", 32'h0000_0003, 32'h0000_0002, 1'b1, 32'h0000_0003, 1'b1, !LOSS_EN);
    tick(1'b0);
    check_out("post_w3", LOSS_EN ? 32'h0 : 32'h0000_0003, !LOSS_EN, !LOSS_EN);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
